// File: rtl/uart.sv
// -----------------------------------------------------------------------------
// uart -- 8N1 asynchronous serial transceiver for the RS-232 link.
//
// Transmit side: host bytes are queued in a small FIFO by one-cycle TRG_WRITE
// strobes and serialised onto TX as start(0) / 8 data bits LSB first / stop(1),
// each bit BIT_DIV = CLK_FREQ/BAUD cycles long. Frames are sent back to back
// while the FIFO holds data.
//
// Receive side: RX is double-flopped, then a falling edge starts a frame,
// which is sampled at the bit centres. A good stop bit loads DATA_OUT and
// pulses DONE for one cycle. A bad stop bit discards the byte. The receiver
// listens continuously when FLOW=1, otherwise only for one frame after each
// TRG_READ strobe.
//
// Ports:
//   CLK_50MHZ  in   system clock, all logic on its rising edge
//   RST        in   synchronous active-high reset
//   RX         in   serial receive line (asynchronous, idle high)
//   TX         out  serial transmit line (idle high)
//   FLOW       in   1 = receiver free-running, 0 = armed by TRG_READ
//   DATA_IN    in   byte to transmit, sampled when TRG_WRITE=1
//   DATA_OUT   out  last correctly received byte
//   TRG_READ   in   one-cycle strobe arming the receiver for one frame
//   TRG_WRITE  in   one-cycle strobe pushing DATA_IN into the TX FIFO
//   DONE       out  one-cycle pulse when DATA_OUT receives a valid byte
// -----------------------------------------------------------------------------
module uart #(
  parameter int CLK_FREQ      = 50000000,
  parameter int BAUD          = 115200,
  parameter int TX_FIFO_DEPTH = 16
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic       RX,
  output logic       TX,
  input  logic       FLOW,
  input  logic [7:0] DATA_IN,
  output logic [7:0] DATA_OUT,
  input  logic       TRG_READ,
  input  logic       TRG_WRITE,
  output logic       DONE
);

  localparam int BIT_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W   = $clog2(BIT_DIV + 1);
  localparam int AW      = $clog2(TX_FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_DIV / 2 - 1);
  localparam logic [AW:0]      FIFO_FULL = (AW + 1)'(TX_FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic [7:0]    fifo_head;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL);
  assign push       = TRG_WRITE && !fifo_full;
  assign fifo_head  = fifo_mem[rd_ptr];

  always_ff @(posedge CLK_50MHZ) begin
    if (push) begin
      fifo_mem[wr_ptr] <= DATA_IN;
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // A push and a pop in the same cycle leave the occupancy unchanged.
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  tx_state_t        tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_idx;
  logic [7:0]       tx_shift;

  // The FSM takes the FIFO head in IDLE, or on the last cycle of a stop bit
  // so that a queued byte starts its start bit with no idle gap.
  assign pop = !fifo_empty &&
               ((tx_state == TX_IDLE) ||
                ((tx_state == TX_STOP) && (tx_cnt == BIT_LAST)));

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      TX       <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          TX     <= 1'b1;
          tx_cnt <= '0;
          if (!fifo_empty) begin
            tx_shift <= fifo_head;
            TX       <= 1'b0;
            tx_state <= TX_START;
          end
        end

        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            TX       <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end

        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_idx == 3'd7) begin
              TX       <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_idx   <= tx_idx + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              TX       <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end

        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (!fifo_empty) begin
              tx_shift <= fifo_head;
              TX       <= 1'b0;
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end

        default: begin
          TX       <= 1'b1;
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receive synchroniser and falling-edge detector
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_sync;
  logic rx_prev;
  logic rx_fall;

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev && !rx_sync;

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_RECOVER
  } rx_state_t;

  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_idx;
  logic [7:0]       rx_shift;
  logic             armed;

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      armed    <= 1'b0;
      DATA_OUT <= '0;
      DONE     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (TRG_READ) begin
        armed <= 1'b1;
      end

      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_fall && (FLOW || armed)) begin
            armed    <= 1'b0;
            rx_state <= RX_START;
          end
        end

        // Half a bit after the edge: a line already back high was a glitch.
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            if (!rx_sync) begin
              rx_idx   <= '0;
              rx_state <= RX_DATA;
            end else begin
              rx_state <= RX_IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end

        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_idx == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              rx_idx <= rx_idx + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end

        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            if (rx_sync) begin
              DATA_OUT <= rx_shift;
              DONE     <= 1'b1;
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_RECOVER;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end

        // Framing error: hold off until the line idles high again so the
        // low stop bit is not mistaken for a new start edge.
        RX_RECOVER: begin
          rx_cnt <= '0;
          if (rx_sync) begin
            rx_state <= RX_IDLE;
          end
        end

        default: begin
          rx_state <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart.sv
// -----------------------------------------------------------------------------
// tb_uart -- directed self-checking bench for uart (default 434 cycles/bit).
// -----------------------------------------------------------------------------
module tb_uart;

  localparam int BIT   = 434;
  localparam int FRAME = 10 * BIT;
  localparam int CAP   = 14010;

  logic       clk;
  logic       rst;
  logic       rx_line;
  logic       tx;
  logic       flow;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       trg_read;
  logic       trg_write;
  logic       done;

  logic       loop_en;
  logic       rx_drv;

  assign rx_line = loop_en ? tx : rx_drv;

  uart #(
    .CLK_FREQ      (50000000),
    .BAUD          (115200),
    .TX_FIFO_DEPTH (16)
  ) dut (
    .CLK_50MHZ (clk),
    .RST       (rst),
    .RX        (rx_line),
    .TX        (tx),
    .FLOW      (flow),
    .DATA_IN   (data_in),
    .DATA_OUT  (data_out),
    .TRG_READ  (trg_read),
    .TRG_WRITE (trg_write),
    .DONE      (done)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // DONE monitor, sampled on the falling edge.
  int         done_cnt = 0;
  int         dbl_cnt  = 0;
  logic       done_prev = 1'b0;
  logic [7:0] rx_log [16];

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (done_cnt < 16) rx_log[done_cnt] = data_out;
      done_cnt++;
      if (done_prev === 1'b1) dbl_cnt++;
    end
    done_prev = done;
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    data_in   = b;
    trg_write = 1'b1;
    wait_cycles(1);
    trg_write = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_drv = 1'b0;
    wait_cycles(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      wait_cycles(BIT);
    end
    rx_drv = stop_bit;
    wait_cycles(BIT);
    rx_drv = 1'b1;
  endtask

  logic       wave [CAP];
  logic [7:0] exp_burst [3];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int t0;
    int base;
    int lows;
    int d0;
    logic [7:0] b;

    exp_burst[0] = 8'h00;
    exp_burst[1] = 8'h0E;
    exp_burst[2] = 8'h03;

    rst       = 1'b1;
    flow      = 1'b1;
    data_in   = 8'h00;
    trg_read  = 1'b0;
    trg_write = 1'b0;
    loop_en   = 1'b0;
    rx_drv    = 1'b1;

    // Reset: 5 cycles with RX low pulses.
    wait_cycles(1);
    rx_drv = 1'b0;
    wait_cycles(1);
    rx_drv = 1'b1;
    wait_cycles(1);
    rx_drv = 1'b0;
    wait_cycles(1);
    rx_drv = 1'b1;
    wait_cycles(1);
    check("rst_tx", tx, 1);
    check("rst_done", done, 0);
    check("rst_data_out", data_out, 8'h00);
    rst = 1'b0;
    wait_cycles(1000);
    check("rst_no_done", done_cnt, 0);
    check("rst_tx_idle", tx, 1);

    // Single write of 0x00.
    push_byte(8'h00);
    lat = 0;
    while (tx !== 1'b0 && lat < 5) begin
      wait_cycles(1);
      lat++;
    end
    check("single_start_lat_ok", (lat >= 1 && lat <= 2), 1);
    n = 0;
    while (tx === 1'b0 && n < 10000) begin
      wait_cycles(1);
      n++;
    end
    check("single_low_len", n, 9 * BIT);
    n = 0;
    while (tx === 1'b1 && n < 1000) begin
      wait_cycles(1);
      n++;
    end
    check("single_high_len", n, 1000);

    // Burst of three bytes, looped back into the receiver.
    loop_en = 1'b1;
    d0 = done_cnt;
    fork
      begin
        push_byte(8'h00);
        wait_cycles(1);
        push_byte(8'h0E);
        wait_cycles(1);
        push_byte(8'h03);
      end
      begin
        for (int t = 0; t < CAP; t++) begin
          wave[t] = tx;
          @(posedge clk);
          #1;
        end
      end
    join
    t0 = -1;
    for (int i = 0; i < 10; i++) begin
      if (wave[i] === 1'b0 && t0 < 0) t0 = i;
    end
    check("burst_start_lat_ok", (t0 >= 1 && t0 <= 2), 1);
    if (t0 < 0) t0 = 0;
    for (int f = 0; f < 3; f++) begin
      base = t0 + f * FRAME;
      for (int k = 0; k < 8; k++) b[k] = wave[base + (k + 1) * BIT + BIT / 2];
      check($sformatf("burst_byte%0d", f), b, exp_burst[f]);
      check($sformatf("burst_start%0d", f), wave[base + BIT / 2], 0);
      check($sformatf("burst_stop%0d", f), wave[base + 9 * BIT + BIT / 2], 1);
    end
    check("burst_edge1_hi", wave[t0 + FRAME - 1], 1);
    check("burst_edge1_lo", wave[t0 + FRAME], 0);
    check("burst_edge2_hi", wave[t0 + 2 * FRAME - 1], 1);
    check("burst_edge2_lo", wave[t0 + 2 * FRAME], 0);
    lows = 0;
    for (int t = t0 + 3 * FRAME - BIT; t < t0 + 3 * FRAME + 900; t++) begin
      if (wave[t] !== 1'b1) lows++;
    end
    check("burst_tail_idle", lows, 0);
    check("loop_done_cnt", done_cnt - d0, 3);
    for (int f = 0; f < 3; f++) begin
      if (d0 + f < 16) check($sformatf("loop_byte%0d", f), rx_log[d0 + f], exp_burst[f]);
    end
    check("loop_data_out", data_out, 8'h03);
    check("done_single_cycle", dbl_cnt, 0);
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    wait_cycles(100);

    // Framing error, then a good frame.
    d0 = done_cnt;
    send_frame(8'hA5, 1'b0);
    wait_cycles(1000);
    check("frm_err_no_done", done_cnt - d0, 0);
    check("frm_err_data_out", data_out, 8'h03);
    send_frame(8'h5A, 1'b1);
    wait_cycles(500);
    check("frm_ok_done", done_cnt - d0, 1);
    check("frm_ok_data_out", data_out, 8'h5A);

    // Arming with FLOW=0.
    flow = 1'b0;
    d0 = done_cnt;
    send_frame(8'h3C, 1'b1);
    wait_cycles(500);
    check("arm_none_no_done", done_cnt - d0, 0);
    check("arm_none_data_out", data_out, 8'h5A);
    trg_read = 1'b1;
    wait_cycles(1);
    trg_read = 1'b0;
    wait_cycles(10);
    send_frame(8'h3C, 1'b1);
    wait_cycles(500);
    check("arm_done", done_cnt - d0, 1);
    check("arm_data_out", data_out, 8'h3C);
    check("done_single_cycle_end", dbl_cnt, 0);
    flow = 1'b1;

    // Reset in the middle of a transmit frame with bytes still queued.
    push_byte(8'h00);
    push_byte(8'h00);
    push_byte(8'h00);
    wait_cycles(1000);
    check("midrst_pre_tx", tx, 0);
    rst = 1'b1;
    wait_cycles(1);
    check("midrst_tx_high", tx, 1);
    wait_cycles(2);
    rst = 1'b0;
    lows = 0;
    for (int t = 0; t < 5000; t++) begin
      if (tx !== 1'b1) lows++;
      wait_cycles(1);
    end
    check("midrst_queue_flushed", lows, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
